// File: rtl/maze_pkg.sv
// Shared maze-game types: direction codes, move FSM states and the
// direction priority picker used by the button front end.
package maze_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_REPEAT = 2'b10
  } move_state_t;

  // Button vectors are indexed by direction code, so the winning index is the code.
  function automatic logic [1:0] pick_dir(input logic [3:0] lvl);
    if (lvl[DIR_UP])         return DIR_UP;
    else if (lvl[DIR_RIGHT]) return DIR_RIGHT;
    else if (lvl[DIR_DOWN])  return DIR_DOWN;
    else                     return DIR_LEFT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw pad.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 26
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_raw,
  output logic o_level
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any cycle agreeing with the current level restarts the stability count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/btn_move_cond.sv
// Button conditioning and move-command generator for the maze game.
// Define BTN_MOVE_AUTO_REPEAT_EN to enable hold-to-repeat moves.
module btn_move_cond
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 15000000,
  parameter int CNT_W           = 26
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BtnU,
  input  logic        BtnD,
  input  logic        BtnL,
  input  logic        BtnR,
  input  logic        BtnC,
  output logic        MoveValid,
  output logic [1:0]  MoveDir,
  input  logic        MoveReady,
  output logic        CenterPulse,
  output logic        Overrun,
  output logic [15:0] MoveCount
);

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                           ((DEBOUNCE_CYCLES > REPEAT_RATE) ? DEBOUNCE_CYCLES : REPEAT_RATE) :
                           ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

  if ((MAX_CYC >> CNT_W) != 0) begin : g_cnt_w_check
    $error("btn_move_cond: CNT_W too narrow for configured cycle counts");
  end

  // Index 0..3 follows the direction code; index 4 is the centre button.
  logic [4:0] w_raw;
  logic [4:0] w_lvl;
  logic [4:0] w_rise;
  logic [4:0] r_lvl_d;

  assign w_raw = {BtnC, BtnL, BtnD, BtnR, BtnU};

  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .Clk    (Clk),
      .Reset  (Reset),
      .i_raw  (w_raw[gi]),
      .o_level(w_lvl[gi])
    );
  end

  assign w_rise = w_lvl & ~r_lvl_d;

  logic [1:0]  w_sel;
  logic        w_any;
  move_state_t r_state, w_state_next;
  logic [1:0]  r_lat_dir, w_lat_next;
  logic        w_gen;

  assign w_sel = pick_dir(w_lvl[3:0]);
  assign w_any = |w_lvl[3:0];

`ifdef BTN_MOVE_AUTO_REPEAT_EN
  logic [CNT_W-1:0] r_timer, w_timer_next;
`endif

  always_comb begin
    w_state_next = r_state;
    w_lat_next   = r_lat_dir;
    w_gen        = 1'b0;
`ifdef BTN_MOVE_AUTO_REPEAT_EN
    w_timer_next = r_timer;
`endif
    case (r_state)
      ST_IDLE: begin
        // Only a fresh edge of the winning direction starts a move.
        if (w_any && w_rise[w_sel]) begin
          w_gen        = 1'b1;
          w_lat_next   = w_sel;
          w_state_next = ST_HOLD;
`ifdef BTN_MOVE_AUTO_REPEAT_EN
          w_timer_next = '0;
`endif
        end
      end
      ST_HOLD: begin
        if (!w_lvl[r_lat_dir]) begin
          w_state_next = ST_IDLE;
        end
`ifdef BTN_MOVE_AUTO_REPEAT_EN
        else if (r_timer == CNT_W'(REPEAT_DELAY - 1)) begin
          w_gen        = 1'b1;
          w_state_next = ST_REPEAT;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + CNT_W'(1);
        end
`endif
      end
      ST_REPEAT: begin
`ifdef BTN_MOVE_AUTO_REPEAT_EN
        if (!w_lvl[r_lat_dir]) begin
          w_state_next = ST_IDLE;
        end else if (r_timer == CNT_W'(REPEAT_RATE - 1)) begin
          w_gen        = 1'b1;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + CNT_W'(1);
        end
`else
        w_state_next = ST_IDLE;
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  logic        r_valid;
  logic [1:0]  r_dir;
  logic        r_center;
  logic        r_overrun;
  logic [15:0] r_move_count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lvl_d      <= '0;
      r_state      <= ST_IDLE;
      r_lat_dir    <= DIR_UP;
      r_valid      <= 1'b0;
      r_dir        <= DIR_UP;
      r_center     <= 1'b0;
      r_overrun    <= 1'b0;
      r_move_count <= '0;
`ifdef BTN_MOVE_AUTO_REPEAT_EN
      r_timer      <= '0;
`endif
    end else begin
      r_lvl_d   <= w_lvl;
      r_state   <= w_state_next;
      r_lat_dir <= w_lat_next;
      r_center  <= w_rise[4];
`ifdef BTN_MOVE_AUTO_REPEAT_EN
      r_timer   <= w_timer_next;
`endif
      // A same-edge accept frees the slot, so the new move may load.
      if (w_gen && (!r_valid || MoveReady)) begin
        r_valid <= 1'b1;
        r_dir   <= w_lat_next;
      end else if (w_gen) begin
        r_overrun <= 1'b1;
      end else if (r_valid && MoveReady) begin
        r_valid <= 1'b0;
      end
      if (r_valid && MoveReady) begin
        r_move_count <= r_move_count + 16'd1;
      end
    end
  end

  assign MoveValid   = r_valid;
  assign MoveDir     = r_dir;
  assign CenterPulse = r_center;
  assign Overrun     = r_overrun;
  assign MoveCount   = r_move_count;

endmodule

// File: tb/tb_btn_move_cond.sv
// Scoreboard bench for btn_move_cond; follows BTN_MOVE_AUTO_REPEAT_EN like the DUT.
module tb_btn_move_cond;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic        Clk = 1'b0;
  logic        Reset, BtnU, BtnD, BtnL, BtnR, BtnC, MoveReady;
  logic        MoveValid, CenterPulse, Overrun;
  logic [1:0]  MoveDir;
  logic [15:0] MoveCount;

  btn_move_cond #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (26)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .BtnU       (BtnU),
    .BtnD       (BtnD),
    .BtnL       (BtnL),
    .BtnR       (BtnR),
    .BtnC       (BtnC),
    .MoveValid  (MoveValid),
    .MoveDir    (MoveDir),
    .MoveReady  (MoveReady),
    .CenterPulse(CenterPulse),
    .Overrun    (Overrun),
    .MoveCount  (MoveCount)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] dir;
    int         cyc;
  } exp_t;

  exp_t mv_q[$];
  int   cp_q[$];
  exp_t e_mon;
  int   c_mon;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_count = 0;
  int   n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge Clk);
    #1;
  endtask

  // Expected cycle is when MoveValid is first seen high; -1 skips the timing check.
  task automatic push_mv(input logic [1:0] d, input int c);
    exp_t e;
    e.dir = d;
    e.cyc = c;
    mv_q.push_back(e);
    exp_count++;
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (MoveValid && MoveReady) begin
        $display("accept dir=%0d cycle=%0d count=%0d", MoveDir, cyc, MoveCount);
        if (mv_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_move: dir %0d at cycle %0d, expected no move", MoveDir, cyc);
        end else begin
          e_mon = mv_q.pop_front();
          check("move_dir", {30'd0, MoveDir}, {30'd0, e_mon.dir});
          if (e_mon.cyc >= 0) check("move_cycle", cyc, e_mon.cyc);
        end
      end
      if (CenterPulse) begin
        $display("center pulse cycle=%0d", cyc);
        if (cp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_center: pulse at cycle %0d, expected none", cyc);
        end else begin
          c_mon = cp_q.pop_front();
          check("center_cycle", cyc, c_mon);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0; BtnC = 1'b0;
    MoveReady = 1'b1;
    tick(3);
    check("rst_valid", {31'd0, MoveValid}, 0);
    check("rst_dir", {30'd0, MoveDir}, 0);
    check("rst_center", {31'd0, CenterPulse}, 0);
    check("rst_overrun", {31'd0, Overrun}, 0);
    check("rst_count", {16'd0, MoveCount}, 0);
    Reset = 1'b0;
    tick(2);

    // Glitch shorter than the debounce window
    BtnU = 1'b1; tick(3); BtnU = 1'b0; tick(15);
    check("glitch_count", {16'd0, MoveCount}, exp_count);

    // Single right press, MoveValid 7 cycles after press
    BtnR = 1'b1; push_mv(2'b01, cyc + 7); tick(10); BtnR = 1'b0; tick(12);
    check("right_count", {16'd0, MoveCount}, exp_count);

    // Long down hold
    BtnD = 1'b1; n = cyc;
    push_mv(2'b10, n + 7);
`ifdef BTN_MOVE_AUTO_REPEAT_EN
    push_mv(2'b10, n + 27); push_mv(2'b10, n + 35); push_mv(2'b10, n + 43);
    push_mv(2'b10, n + 51); push_mv(2'b10, n + 59);
`endif
    tick(60); BtnD = 1'b0; tick(15);
    check("down_count", {16'd0, MoveCount}, exp_count);

    // Left held with consumer stalled
    MoveReady = 1'b0; BtnL = 1'b1; push_mv(2'b11, -1);
    tick(20);
    check("stall_valid", {31'd0, MoveValid}, 1);
    check("stall_dir", {30'd0, MoveDir}, 3);
    check("stall_overrun_pre", {31'd0, Overrun}, 0);
    tick(8);
`ifdef BTN_MOVE_AUTO_REPEAT_EN
    check("stall_overrun", {31'd0, Overrun}, 1);
`else
    check("stall_overrun", {31'd0, Overrun}, 0);
`endif
    check("stall_dir_hold", {30'd0, MoveDir}, 3);
    BtnL = 1'b0; tick(10);
    MoveReady = 1'b1; tick(3);
    check("stall_valid_clr", {31'd0, MoveValid}, 0);
    check("stall_count", {16'd0, MoveCount}, exp_count);

    // Up and left together: only up, no left on up release
    BtnU = 1'b1; BtnL = 1'b1; push_mv(2'b00, cyc + 7);
    tick(10); BtnU = 1'b0; tick(20); BtnL = 1'b0; tick(12);
    check("prio_count", {16'd0, MoveCount}, exp_count);

    // Centre button
    BtnC = 1'b1; cp_q.push_back(cyc + 7); tick(10); BtnC = 1'b0; tick(12);
    check("center_count", {16'd0, MoveCount}, exp_count);

    // Reset while a move is pending, button held through reset
    MoveReady = 1'b0; BtnD = 1'b1; tick(8);
    check("pre_rst_valid", {31'd0, MoveValid}, 1);
    check("pre_rst_dir", {30'd0, MoveDir}, 2);
    Reset = 1'b1; tick(1);
    check("mid_rst_valid", {31'd0, MoveValid}, 0);
    check("mid_rst_dir", {30'd0, MoveDir}, 0);
    check("mid_rst_overrun", {31'd0, Overrun}, 0);
    check("mid_rst_count", {16'd0, MoveCount}, 0);
    exp_count = 0;
    Reset = 1'b0; MoveReady = 1'b1;
    push_mv(2'b10, cyc + D + 3);
    tick(10); BtnD = 1'b0; tick(12);
    check("post_rst_count", {16'd0, MoveCount}, exp_count);

    // Counter wrap from 16'hFFFF
    force dut.r_move_count = 16'hFFFF;
    @(negedge Clk);
    release dut.r_move_count;
    tick(1);
    check("wrap_preload", {16'd0, MoveCount}, 32'h0000_FFFF);
    exp_count = 32'h0000_FFFF;
    BtnR = 1'b1; push_mv(2'b01, cyc + 7); tick(10); BtnR = 1'b0; tick(12);
    check("wrap_count", {16'd0, MoveCount}, {16'd0, exp_count[15:0]});

    check("moves_drained", mv_q.size(), 0);
    check("centers_drained", cp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
